benes_route_sequencer: RTL and testbench
========================================

// Module: benes_route_sequencer
// PURPOSE
//  Upstream control stage for the dual Benes interconnect (RAM->module and module->RAM networks).
//  Stores a programmable table of per-cycle switch configurations for both networks.
//  On start, replays the table one entry per clock onto the two select buses that feed the interconnect.
//  Replay is one-shot or looping.
// PARAMETERS
//  PORT_NUM    32                       network ports
//  SWITCH_NUM  PORT_NUM/2               2x2 switches per stage
//  STAGE_NUM   2*$clog2(PORT_NUM)-1     Benes stages
//  CFG_DEPTH   16                       table entries (power of 2)
//  ADDR_W      $clog2(CFG_DEPTH)        table address width
//  LEN_W       ADDR_W+1                 schedule length width
// PORTS
//  CLK              in   1                    clock
//  RST_N            in   1                    async active-low reset
//  I_CFG_WE         in   1                    table write strobe
//  I_CFG_ADDR       in   ADDR_W               table write address
//  I_CFG_MOD_SEL    in   STAGE_NUM*SWITCH_NUM RAM->module switch word
//  I_CFG_SLOT_SEL   in   STAGE_NUM*SWITCH_NUM module->RAM switch word
//  I_START          in   1                    start replay (pulse)
//  I_STOP           in   1                    abort replay (pulse)
//  I_LEN            in   LEN_W                entries to replay, sampled at start
//  I_LOOP           in   1                    wrap to entry 0 after the last entry, sampled at start
//  O_MODULE_SELECT  out  [0:STAGE_NUM-1][0:SWITCH_NUM-1]  RAM->module switch settings
//  O_SLOT_SELECT    out  [0:STAGE_NUM-1][0:SWITCH_NUM-1]  module->RAM switch settings
//  O_VALID          out  1                    select buses carry a live entry
//  O_IDX            out  ADDR_W               index of the entry on the buses
//  O_BUSY           out  1                    state != IDLE
//  O_DONE           out  1                    one-cycle pulse at end of a one-shot replay
//  O_WR_REJECT      out  1                    one-cycle pulse: write arrived while not IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE. Table contents are not reset.
//  FSM IDLE->RUN->DONE->IDLE.
//   - IDLE->RUN: I_START=1 and I_LEN!=0. A start with I_LEN==0 is ignored.
//   - RUN->DONE: last entry issued and loop=0.
//   - DONE->IDLE: unconditional; O_DONE=1 during the DONE cycle.
//   - RUN->IDLE: I_STOP=1. Takes effect next cycle, no O_DONE; I_STOP wins over a wrap.
//  Length clamp: I_LEN>CFG_DEPTH is clamped to CFG_DEPTH.
//  Latency: start accepted at cycle t -> entry 0 on buses with O_VALID=1 at t+1.
//   - Then one entry per cycle, idx 0..len-1.
//   - Bus fields map [stage][switch] = word bit stage*SWITCH_NUM+switch.
//  Looping: loop=1 wraps idx from len-1 to 0 with no bubble.
//  Outside RUN: O_VALID=0; select buses hold the last issued entry, so the network stays stable.
//  Writes:
//   - Accepted only in IDLE.
//   - A write in RUN or DONE is dropped and raises O_WR_REJECT the next cycle.
//  Same-cycle write+start in IDLE: write-first; entry 0 shows the new data if ADDR==0.
//  I_START while BUSY: ignored.
//  Async reset mid-RUN: outputs go to 0 immediately; state returns to IDLE.
// CONFIGURATION
//  BENES_SEQ_UNWRITTEN_CHK_EN defined:
//   - Per-entry written flag, cleared by reset.
//   - Extra output O_CFG_ERR: sticky, set when RUN issues an unwritten entry; cleared by the next accepted start.
//   - The entry is still issued.
//  Not defined: no flags, no O_CFG_ERR port.
// TESTING
//  T1 reset: RST_N low mid-RUN -> all outputs 0 asynchronously, O_BUSY=0 after release.
//  T2 one-shot: write entries 0..3 with distinct patterns; START with LEN=4, LOOP=0
//   -> O_VALID for 4 cycles beginning t+1, O_IDX 0,1,2,3 with patterns on buses;
//   -> O_DONE pulse at t+5; buses hold entry 3.
//  T3 loop+stop: LEN=3, LOOP=1 -> idx 0,1,2,0,1,2 with no gap; STOP at idx 1 -> O_VALID=0 next cycle, no O_DONE.
//  T4 corners:
//   - LEN=0 start -> stays IDLE.
//   - LEN=20 -> 16 entries issued.
//   - START while BUSY -> no restart.
//   - Write during RUN -> O_WR_REJECT pulse, table unchanged.
//  T5 same cycle: write ADDR=0 data=A plus START, LEN=1 -> buses show A at t+1.
//  T6 (CHK_EN): run LEN=2 with only entry 0 written -> O_CFG_ERR=1 after idx 1; next start clears it.

Source files
------------

// File: rtl/benes_route_sequencer_if.sv
// Port bundle for benes_route_sequencer: table writes, replay control and the two select buses.
// O_CFG_ERR is present only when BENES_SEQ_UNWRITTEN_CHK_EN is defined.
interface benes_route_sequencer_if #(
    parameter int PORT_NUM  = 32,
    parameter int CFG_DEPTH = 16
);
    localparam int SWITCH_NUM = PORT_NUM / 2;
    localparam int STAGE_NUM  = 2 * $clog2(PORT_NUM) - 1;
    localparam int WORD_W     = STAGE_NUM * SWITCH_NUM;
    localparam int ADDR_W     = $clog2(CFG_DEPTH);
    localparam int LEN_W      = ADDR_W + 1;

    logic                                 I_CFG_WE;
    logic [ADDR_W-1:0]                    I_CFG_ADDR;
    logic [WORD_W-1:0]                    I_CFG_MOD_SEL;
    logic [WORD_W-1:0]                    I_CFG_SLOT_SEL;
    logic                                 I_START;
    logic                                 I_STOP;
    logic [LEN_W-1:0]                     I_LEN;
    logic                                 I_LOOP;
    logic [0:STAGE_NUM-1][0:SWITCH_NUM-1] O_MODULE_SELECT;
    logic [0:STAGE_NUM-1][0:SWITCH_NUM-1] O_SLOT_SELECT;
    logic                                 O_VALID;
    logic [ADDR_W-1:0]                    O_IDX;
    logic                                 O_BUSY;
    logic                                 O_DONE;
    logic                                 O_WR_REJECT;
    logic [1:0]                           dbg_state;
`ifdef BENES_SEQ_UNWRITTEN_CHK_EN
    logic                                 O_CFG_ERR;
`endif

    modport slave (
        input  I_CFG_WE, I_CFG_ADDR, I_CFG_MOD_SEL, I_CFG_SLOT_SEL,
        input  I_START, I_STOP, I_LEN, I_LOOP,
        output O_MODULE_SELECT, O_SLOT_SELECT, O_VALID, O_IDX,
        output O_BUSY, O_DONE, O_WR_REJECT, dbg_state
`ifdef BENES_SEQ_UNWRITTEN_CHK_EN
        , output O_CFG_ERR
`endif
    );

    modport master (
        output I_CFG_WE, I_CFG_ADDR, I_CFG_MOD_SEL, I_CFG_SLOT_SEL,
        output I_START, I_STOP, I_LEN, I_LOOP,
        input  O_MODULE_SELECT, O_SLOT_SELECT, O_VALID, O_IDX,
        input  O_BUSY, O_DONE, O_WR_REJECT, dbg_state
`ifdef BENES_SEQ_UNWRITTEN_CHK_EN
        , input O_CFG_ERR
`endif
    );
endinterface

// File: rtl/benes_route_sequencer.sv
// Replays a programmable table of Benes switch settings (RAM->module and module->RAM) one entry per clock.
// Optional BENES_SEQ_UNWRITTEN_CHK_EN adds per-entry written flags and a sticky O_CFG_ERR output.
module benes_route_sequencer #(
    parameter int PORT_NUM  = 32,
    parameter int CFG_DEPTH = 16
) (
    input logic                   CLK,
    input logic                   RST_N,
    benes_route_sequencer_if.slave bus
);
    localparam int SWITCH_NUM = PORT_NUM / 2;
    localparam int STAGE_NUM  = 2 * $clog2(PORT_NUM) - 1;
    localparam int WORD_W     = STAGE_NUM * SWITCH_NUM;
    localparam int ADDR_W     = $clog2(CFG_DEPTH);
    localparam int LEN_W      = ADDR_W + 1;

    // Control semantics: I_START/I_STOP/I_CFG_WE are single-cycle strobes sampled on every rising
    // edge; there is no back-pressure. O_VALID qualifies the select buses for exactly one cycle per entry.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                loop_q, loop_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                valid_q, valid_d;
    logic                wr_reject_q, wr_reject_d;
    logic [WORD_W-1:0]   mod_sel_q, mod_sel_d;
    logic [WORD_W-1:0]   slot_sel_q, slot_sel_d;

    logic [WORD_W-1:0]   mod_tbl_q  [CFG_DEPTH];
    logic [WORD_W-1:0]   slot_tbl_q [CFG_DEPTH];

    logic                cfg_wr_en;
    logic [LEN_W-1:0]    len_clamped;
    logic                last_entry;
    logic                load_en;
    logic [ADDR_W-1:0]   load_idx;
    logic                fwd;
    logic [WORD_W-1:0]   load_mod;
    logic [WORD_W-1:0]   load_slot;

    assign cfg_wr_en   = bus.I_CFG_WE && (state_q == ST_IDLE);
    assign len_clamped = (bus.I_LEN > LEN_W'(CFG_DEPTH)) ? LEN_W'(CFG_DEPTH) : bus.I_LEN;
    assign last_entry  = ({1'b0, idx_q} == (len_q - LEN_W'(1)));

    always_ff @(posedge CLK) begin
        if (cfg_wr_en) begin
            mod_tbl_q[bus.I_CFG_ADDR]  <= bus.I_CFG_MOD_SEL;
            slot_tbl_q[bus.I_CFG_ADDR] <= bus.I_CFG_SLOT_SEL;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        loop_d      = loop_q;
        idx_d       = idx_q;
        valid_d     = 1'b0;
        load_en     = 1'b0;
        load_idx    = '0;
        wr_reject_d = bus.I_CFG_WE && (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (bus.I_START && (bus.I_LEN != '0)) begin
                    state_d  = ST_RUN;
                    len_d    = len_clamped;
                    loop_d   = bus.I_LOOP;
                    idx_d    = '0;
                    valid_d  = 1'b1;
                    load_en  = 1'b1;
                    load_idx = '0;
                end
            end
            ST_RUN: begin
                // Stop is checked first so it also overrides a loop wrap.
                if (bus.I_STOP) begin
                    state_d = ST_IDLE;
                end else if (last_entry) begin
                    if (loop_q) begin
                        idx_d    = '0;
                        valid_d  = 1'b1;
                        load_en  = 1'b1;
                        load_idx = '0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    idx_d    = idx_q + ADDR_W'(1);
                    valid_d  = 1'b1;
                    load_en  = 1'b1;
                    load_idx = idx_q + ADDR_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A same-cycle write to the entry being loaded is forwarded (write-first).
    always_comb begin
        fwd        = cfg_wr_en && (bus.I_CFG_ADDR == load_idx);
        load_mod   = fwd ? bus.I_CFG_MOD_SEL  : mod_tbl_q[load_idx];
        load_slot  = fwd ? bus.I_CFG_SLOT_SEL : slot_tbl_q[load_idx];
        mod_sel_d  = mod_sel_q;
        slot_sel_d = slot_sel_q;
        if (load_en) begin
            mod_sel_d  = load_mod;
            slot_sel_d = load_slot;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            loop_q      <= 1'b0;
            idx_q       <= '0;
            valid_q     <= 1'b0;
            wr_reject_q <= 1'b0;
            mod_sel_q   <= '0;
            slot_sel_q  <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            loop_q      <= loop_d;
            idx_q       <= idx_d;
            valid_q     <= valid_d;
            wr_reject_q <= wr_reject_d;
            mod_sel_q   <= mod_sel_d;
            slot_sel_q  <= slot_sel_d;
        end
    end

`ifdef BENES_SEQ_UNWRITTEN_CHK_EN
    logic [CFG_DEPTH-1:0] written_q, written_d;
    logic                 cfg_err_q, cfg_err_d;
    logic                 load_written;

    // A new start clears the sticky error before judging entry 0.
    always_comb begin
        written_d = written_q;
        if (cfg_wr_en) written_d[bus.I_CFG_ADDR] = 1'b1;
        load_written = fwd || written_q[load_idx];
        cfg_err_d    = cfg_err_q;
        if (load_en) begin
            cfg_err_d = ((state_q == ST_IDLE) ? 1'b0 : cfg_err_q) | ~load_written;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            written_q <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            written_q <= written_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign bus.O_CFG_ERR = cfg_err_q;
`endif

    always_comb begin
        bus.O_MODULE_SELECT = '0;
        bus.O_SLOT_SELECT   = '0;
        for (int s = 0; s < STAGE_NUM; s++) begin
            for (int w = 0; w < SWITCH_NUM; w++) begin
                bus.O_MODULE_SELECT[s][w] = mod_sel_q[s*SWITCH_NUM + w];
                bus.O_SLOT_SELECT[s][w]   = slot_sel_q[s*SWITCH_NUM + w];
            end
        end
    end

    assign bus.O_VALID     = valid_q;
    assign bus.O_IDX       = idx_q;
    assign bus.O_BUSY      = (state_q != ST_IDLE);
    assign bus.O_DONE      = (state_q == ST_DONE);
    assign bus.O_WR_REJECT = wr_reject_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_benes_route_sequencer.sv
// Bench for benes_route_sequencer: vector table of replay scenarios plus hand-written reset,
// write+start and (with BENES_SEQ_UNWRITTEN_CHK_EN) unwritten-entry sequences.
module tb_benes_route_sequencer;
    localparam int PORT_NUM = 32;
    localparam int DEPTH    = 16;
    localparam int SW       = PORT_NUM / 2;
    localparam int ST       = 2 * $clog2(PORT_NUM) - 1;
    localparam int WORD_W   = ST * SW;
    localparam int ADDR_W   = $clog2(DEPTH);
    localparam int LEN_W    = ADDR_W + 1;
    localparam int EXP_W    = ADDR_W + 2 * WORD_W;

    typedef logic [0:ST-1][0:SW-1] sel_t;

    typedef struct {
        int len;
        bit loop;
        int stop_at;
        int restart_at;
        int wr_at;
        int exp_issued;
        int exp_done;
        int exp_reject;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    logic [EXP_W-1:0]  exp_q[$];
    logic [EXP_W-1:0]  got_e;
    logic [EXP_W-1:0]  exp_e;
    logic [WORD_W-1:0] sh_mod  [DEPTH];
    logic [WORD_W-1:0] sh_slot [DEPTH];

    benes_route_sequencer_if #(.PORT_NUM(PORT_NUM), .CFG_DEPTH(DEPTH)) bus ();

    benes_route_sequencer #(.PORT_NUM(PORT_NUM), .CFG_DEPTH(DEPTH)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    function automatic logic [WORD_W-1:0] flatten(input sel_t s);
        logic [WORD_W-1:0] r;
        r = '0;
        for (int i = 0; i < ST; i++)
            for (int j = 0; j < SW; j++)
                r[i*SW + j] = s[i][j];
        return r;
    endfunction

    function automatic logic [WORD_W-1:0] rand_word();
        logic [WORD_W-1:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) r = (r << 32) | WORD_W'($urandom);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_wide(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_entry(input int idx);
        exp_q.push_back({ADDR_W'(idx), sh_mod[idx], sh_slot[idx]});
    endtask

    task automatic write_entry(input int addr, input logic [WORD_W-1:0] m, input logic [WORD_W-1:0] s);
        bus.I_CFG_WE       = 1'b1;
        bus.I_CFG_ADDR     = ADDR_W'(addr);
        bus.I_CFG_MOD_SEL  = m;
        bus.I_CFG_SLOT_SEL = s;
        sh_mod[addr]       = m;
        sh_slot[addr]      = s;
        tick();
        bus.I_CFG_WE = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " valid"},  32'(bus.O_VALID), 0);
        chk({tag, " idx"},    32'(bus.O_IDX), 0);
        chk({tag, " busy"},   32'(bus.O_BUSY), 0);
        chk({tag, " done"},   32'(bus.O_DONE), 0);
        chk({tag, " reject"}, 32'(bus.O_WR_REJECT), 0);
        chk({tag, " state"},  32'(bus.dbg_state), 0);
        chk_wide({tag, " mod bus"},  flatten(bus.O_MODULE_SELECT), '0);
        chk_wide({tag, " slot bus"}, flatten(bus.O_SLOT_SELECT), '0);
    endtask

    // Scoreboard: every live entry on the buses must match the head of exp_q.
    always @(negedge clk) begin
        if (rst_n && bus.O_VALID) begin
            got_e = {bus.O_IDX, flatten(bus.O_MODULE_SELECT), flatten(bus.O_SLOT_SELECT)};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL entry: got idx %0d expected no live entry", bus.O_IDX);
            end else begin
                exp_e = exp_q.pop_front();
                if (got_e !== exp_e) begin
                    n_errors++;
                    $display("FAIL entry: got idx %0d mod %h slot %h expected idx %0d mod %h slot %h",
                             got_e[EXP_W-1 -: ADDR_W], got_e[2*WORD_W-1 -: WORD_W], got_e[WORD_W-1:0],
                             exp_e[EXP_W-1 -: ADDR_W], exp_e[2*WORD_W-1 -: WORD_W], exp_e[WORD_W-1:0]);
                end
            end
        end
    end

    task automatic run_case(input vec_t v, input string name);
        int eff, n_valid, n_done, n_rej, first_v, last_v, done_cyc;
        bit timed_out;
        eff = (v.len > DEPTH) ? DEPTH : v.len;
        for (int k = 0; k < v.exp_issued; k++) push_entry(k % eff);
        bus.I_START = 1'b1;
        bus.I_LEN   = LEN_W'(v.len);
        bus.I_LOOP  = v.loop;
        tick();
        bus.I_START  = 1'b0;
        bus.I_CFG_WE = 1'b0;
        n_valid = 0; n_done = 0; n_rej = 0; first_v = 0; last_v = 0; done_cyc = 0;
        timed_out = 1'b1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (bus.O_VALID) begin
                n_valid++;
                if (first_v == 0) first_v = cyc;
                last_v = cyc;
            end
            if (bus.O_DONE) begin
                n_done++;
                done_cyc = cyc;
            end
            if (bus.O_WR_REJECT) n_rej++;
            if (!bus.O_BUSY) begin
                timed_out = 1'b0;
                break;
            end
            bus.I_START  = 1'b0;
            bus.I_STOP   = 1'b0;
            bus.I_CFG_WE = 1'b0;
            if (bus.O_VALID && v.stop_at != 0 && n_valid == v.stop_at) bus.I_STOP = 1'b1;
            if (bus.O_VALID && v.restart_at != 0 && n_valid == v.restart_at) begin
                bus.I_START = 1'b1;
                bus.I_LEN   = LEN_W'(2);
                bus.I_LOOP  = 1'b0;
            end
            if (bus.O_VALID && v.wr_at != 0 && n_valid == v.wr_at) begin
                bus.I_CFG_WE       = 1'b1;
                bus.I_CFG_ADDR     = ADDR_W'(2);
                bus.I_CFG_MOD_SEL  = ~sh_mod[2];
                bus.I_CFG_SLOT_SEL = ~sh_slot[2];
            end
            tick();
        end
        bus.I_START = 1'b0; bus.I_STOP = 1'b0; bus.I_CFG_WE = 1'b0;
        chk({name, " timeout"}, 32'(timed_out), 0);
        if (timed_out) begin
            bus.I_STOP = 1'b1;
            tick();
            bus.I_STOP = 1'b0;
        end
        chk({name, " issued"},  n_valid, v.exp_issued);
        chk({name, " done pulses"}, n_done, v.exp_done);
        chk({name, " rejects"}, n_rej, v.exp_reject);
        if (n_valid > 0) begin
            chk({name, " first valid cycle"}, first_v, 1);
            chk({name, " no bubble"}, last_v, n_valid);
        end
        if (v.exp_done != 0) chk({name, " done cycle"}, done_cyc, last_v + 1);
        chk({name, " pending entries"}, exp_q.size(), 0);
        exp_q.delete();
        chk({name, " valid after"}, 32'(bus.O_VALID), 0);
        if (v.exp_issued > 0) begin
            chk_wide({name, " mod hold"},  flatten(bus.O_MODULE_SELECT), sh_mod[(v.exp_issued - 1) % eff]);
            chk_wide({name, " slot hold"}, flatten(bus.O_SLOT_SELECT), sh_slot[(v.exp_issued - 1) % eff]);
        end
    endtask

    vec_t vecs[10];

    initial begin
        //            len loop stop rst wr iss done rej
        vecs[0] = '{ 4, 1'b0, 0,  0, 0,  4, 1, 0};  // one-shot
        vecs[1] = '{ 3, 1'b1, 8,  0, 0,  8, 0, 0};  // loop, stop at idx 1
        vecs[2] = '{ 0, 1'b0, 0,  0, 0,  0, 0, 0};  // zero length ignored
        vecs[3] = '{20, 1'b0, 0,  0, 0, 16, 1, 0};  // length clamp
        vecs[4] = '{ 4, 1'b0, 0,  2, 0,  4, 1, 0};  // start while busy
        vecs[5] = '{ 6, 1'b0, 0,  0, 3,  6, 1, 1};  // write while running
        vecs[6] = '{ 4, 1'b0, 0,  0, 0,  4, 1, 0};  // entry 2 still original
        vecs[7] = '{16, 1'b1, 17, 0, 0, 17, 0, 0};  // full-depth wrap
        vecs[8] = '{ 5, 1'b0, 4,  0, 0,  4, 0, 0};  // stop before last
        vecs[9] = '{ 3, 1'b1, 3,  0, 0,  3, 0, 0};  // stop beats wrap

        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.I_CFG_WE = 1'b0; bus.I_CFG_ADDR = '0; bus.I_CFG_MOD_SEL = '0; bus.I_CFG_SLOT_SEL = '0;
        bus.I_START = 1'b0; bus.I_STOP = 1'b0; bus.I_LEN = '0; bus.I_LOOP = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
`ifdef BENES_SEQ_UNWRITTEN_CHK_EN
        chk("reset cfg_err", 32'(bus.O_CFG_ERR), 0);
`endif
        rst_n = 1'b1;
        tick();

        for (int a = 0; a < DEPTH; a++) write_entry(a, rand_word(), rand_word());

        for (int i = 0; i < 10; i++) run_case(vecs[i], $sformatf("vec%0d", i));

        // Same-cycle write to entry 0 with a start: the new data must be issued.
        bus.I_CFG_WE       = 1'b1;
        bus.I_CFG_ADDR     = '0;
        bus.I_CFG_MOD_SEL  = rand_word();
        bus.I_CFG_SLOT_SEL = rand_word();
        sh_mod[0]  = bus.I_CFG_MOD_SEL;
        sh_slot[0] = bus.I_CFG_SLOT_SEL;
        run_case('{1, 1'b0, 0, 0, 0, 1, 1, 0}, "write+start");

        // Asynchronous reset in the middle of a looping run.
        for (int k = 0; k < 3; k++) push_entry(k);
        bus.I_START = 1'b1; bus.I_LEN = LEN_W'(16); bus.I_LOOP = 1'b1;
        tick();
        bus.I_START = 1'b0;
        tick();
        tick();
        #6;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async reset");
        chk("async reset pending", exp_q.size(), 0);
        exp_q.delete();
        tick();
        chk("reset held busy", 32'(bus.O_BUSY), 0);
        rst_n = 1'b1;
        tick();
        chk("after release busy", 32'(bus.O_BUSY), 0);
        chk("after release valid", 32'(bus.O_VALID), 0);

`ifdef BENES_SEQ_UNWRITTEN_CHK_EN
        // Reset cleared the written flags while the table kept its contents.
        chk("flags cleared cfg_err", 32'(bus.O_CFG_ERR), 0);
        write_entry(0, rand_word(), rand_word());
        run_case('{2, 1'b0, 0, 0, 0, 2, 1, 0}, "unwritten run");
        chk("cfg_err set", 32'(bus.O_CFG_ERR), 1);
        run_case('{1, 1'b0, 0, 0, 0, 1, 1, 0}, "clean run");
        chk("cfg_err cleared", 32'(bus.O_CFG_ERR), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
